// File: rtl/hack_loader_pkg.sv
// Shared definitions for the Hack instruction-ROM loader: state encoding,
// ROM address / word widths and the maximum frame length in words.
package hack_loader_pkg;

  localparam int ROM_AW = 15;
  localparam int WORD_W = 16;

  // Largest legal word count: fills the whole 32K-word instruction ROM.
  localparam logic [WORD_W-1:0] MAX_LEN = 16'h8000;

  // CHK_HI/CHK_LO are only reachable when LOADER_CHECKSUM_EN is defined.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    DONE    = 4'd6,
    ERR     = 4'd7,
    CHK_HI  = 4'd8,
    CHK_LO  = 4'd9
  } state_t;

endpackage

// File: rtl/hack_byte_pair.sv
// Assembles big-endian byte pairs into 16-bit words.
// o_pair is the combinational {held high byte, current byte} used for the
// length and checksum decisions; o_word/o_word_valid are the registered word
// and its one-cycle strobe, which drive the ROM write port directly.
module hack_byte_pair
  import hack_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_byte,
  input  logic              i_hi_take,
  input  logic              i_lo_take,
  output logic [WORD_W-1:0] o_pair,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [7:0]        r_hi;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;

  assign o_pair       = {r_hi, i_byte};
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

  // Hold the high byte, then latch the full word and pulse valid on the low byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi         <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_lo_take;
      if (i_hi_take) r_hi <= i_byte;
      if (i_lo_take) r_word <= {r_hi, i_byte};
    end
  end

endmodule

// File: rtl/hack_rom_loader.sv
// Serial-link loader for the Hack instruction ROM. Frame: 16-bit word count N
// (high byte first) followed by N 16-bit words (high byte first). The CPU is
// held in reset except while DONE.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 16-bit
// mod-2^16 sum of all words; a mismatch ends in ERR.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | expecting high byte of word count
// LEN_LO  | expecting low byte of word count; decides DONE / ERR / DATA_HI
// DATA_HI | expecting high byte of next word
// DATA_LO | expecting low byte of next word
// WRITE   | one-cycle ROM write strobe, address advances afterwards
// CHK_HI  | expecting high byte of checksum (checksum build only)
// CHK_LO  | expecting low byte of checksum (checksum build only)
// DONE    | load complete, CPU released; start reloads
// ERR     | bad length or checksum, CPU held; start reloads
module hack_rom_loader
  import hack_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            r_state, w_next;
  logic [ROM_AW-1:0] r_addr;
  logic [WORD_W-1:0] r_remaining;
  logic [WORD_W-1:0] w_pair;
  logic              w_xfer, w_hi_take, w_lo_take, w_len_load, w_write;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                    (r_state == DATA_HI) || (r_state == DATA_LO) ||
                    (r_state == CHK_HI) || (r_state == CHK_LO);
`else
  assign in_ready = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                    (r_state == DATA_HI) || (r_state == DATA_LO);
`endif
  assign w_xfer   = in_valid & in_ready;
  assign w_write  = (r_state == WRITE);
  assign rom_addr = r_addr;

  hack_byte_pair u_pair (
    .i_clk        (CLK),
    .i_rst        (reset),
    .i_byte       (in_byte),
    .i_hi_take    (w_hi_take),
    .i_lo_take    (w_lo_take),
    .o_pair       (w_pair),
    .o_word       (rom_data),
    .o_word_valid (rom_we)
  );

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Address counter and remaining-word down-counter; rearmed on a legal length.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_len_load) begin
      r_addr      <= '0;
      r_remaining <= w_pair;
    end else if (w_write) begin
      r_addr      <= r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running mod-2^16 sum of every word written in this load.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)           r_sum <= '0;
    else if (w_len_load) r_sum <= '0;
    else if (w_write)    r_sum <= r_sum + rom_data;
  end
`endif

  // Next-state and status decode.
  always_comb begin
    w_next     = r_state;
    w_hi_take  = 1'b0;
    w_lo_take  = 1'b0;
    w_len_load = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (r_state)
      IDLE: if (start) w_next = LEN_HI;
      LEN_HI: begin
        busy = 1'b1;
        if (w_xfer) begin
          w_hi_take = 1'b1;
          w_next    = LEN_LO;
        end
      end
      LEN_LO: begin
        busy = 1'b1;
        if (w_xfer) begin
          if (w_pair == '0)          w_next = DONE;
          else if (w_pair > MAX_LEN) w_next = ERR;
          else begin
            w_next     = DATA_HI;
            w_len_load = 1'b1;
          end
        end
      end
      DATA_HI: begin
        busy = 1'b1;
        if (w_xfer) begin
          w_hi_take = 1'b1;
          w_next    = DATA_LO;
        end
      end
      DATA_LO: begin
        busy = 1'b1;
        if (w_xfer) begin
          w_lo_take = 1'b1;
          w_next    = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        w_next = (r_remaining == 16'd1) ? CHK_HI : DATA_HI;
`else
        w_next = (r_remaining == 16'd1) ? DONE : DATA_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK_HI: begin
        busy = 1'b1;
        if (w_xfer) begin
          w_hi_take = 1'b1;
          w_next    = CHK_LO;
        end
      end
      CHK_LO: begin
        busy = 1'b1;
        if (w_xfer) w_next = (w_pair == r_sum) ? DONE : ERR;
      end
`endif
      DONE: begin
        done      = 1'b1;
        cpu_reset = start;
        if (start) w_next = LEN_HI;
      end
      ERR: begin
        error = 1'b1;
        if (start) w_next = LEN_HI;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader. Expected ROM writes are queued as the
// stimulus is driven; a negedge monitor pops and compares each strobe.
module tb_hack_rom_loader;
  import hack_loader_pkg::*;

  logic              CLK = 1'b0;
  logic              reset, start, in_valid;
  logic [7:0]        in_byte;
  logic              in_ready, rom_we, cpu_reset, busy, done, error;
  logic [ROM_AW-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [30:0] sb[$];

  hack_rom_loader dut (
    .CLK(CLK), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued write.
  always @(negedge CLK) begin
    if (reset === 1'b0 && rom_we === 1'b1) begin
      if (sb.size() == 0) check("unexpected_rom_we", {16'd0, rom_data}, 32'hFFFF_FFFF);
      else begin
        logic [30:0] e;
        e = sb.pop_front();
        check("we_addr", {17'd0, rom_addr}, {17'd0, e[30:16]});
        check("we_data", {16'd0, rom_data}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Offer a byte after `idle` empty cycles; returns 1 ns after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int idle);
    int n;
    in_valid = 1'b0;
    repeat (idle) tick();
    in_valid = 1'b1; in_byte = b; n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check("in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [14:0] a, input logic [15:0] w, input int idle);
    sb.push_back({a, w});
    send_byte(w[15:8], idle);
    send_byte(w[7:0], idle);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_rom_we"},    {31'd0, rom_we},    32'd0);
    check({tag, "_rom_addr"},  {17'd0, rom_addr},  32'd0);
    check({tag, "_rom_data"},  {16'd0, rom_data},  32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_status"},    {29'd0, busy, done, error}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    #1 reset = 1'b1;
    #1 check_reset_vals("por");
    tick(); tick();
    reset = 1'b0;
    tick();
    check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // Two words 1234, ABCD.
    pulse_start();
    check("ld1_busy", {29'd0, busy, done, error}, 32'b100);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(15'd0, 16'h1234, 0);
    send_word(15'd1, 16'hABCD, 0);
`ifndef LOADER_CHECKSUM_EN
    check("ld1_last_we", {31'd0, rom_we}, 32'd1);
    check("ld1_cpu_reset_held", {31'd0, cpu_reset}, 32'd1);
    tick();
`else
    send_byte(8'hBE, 0); send_byte(8'h01, 0);
`endif
    check("ld1_cpu_reset_fall", {31'd0, cpu_reset}, 32'd0);
    check("ld1_done", {29'd0, busy, done, error}, 32'b010);

    // Reload from DONE with N=0.
    pulse_start();
    check("ld2_cpu_reset_back", {31'd0, cpu_reset}, 32'd1);
    check("ld2_busy", {29'd0, busy, done, error}, 32'b100);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("ld2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("ld2_done", {29'd0, busy, done, error}, 32'b010);
    check("ld2_no_we", {31'd0, rom_we}, 32'd0);

    // Oversize length 0x8001.
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h01, 0);
    check("ld3_err", {29'd0, busy, done, error}, 32'b001);
    check("ld3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("ld3_in_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    check("ld3_err_held", {29'd0, busy, done, error}, 32'b001);

    // N=1, five idle cycles between bytes; a stray start mid-load is ignored.
    pulse_start();
    pulse_start();
    check("ld4_start_ignored", {31'd0, in_ready}, 32'd1);
    send_byte(8'h00, 5); send_byte(8'h01, 5);
    send_word(15'd0, 16'h0007, 5);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 5); send_byte(8'h07, 5);
`else
    tick();
`endif
    repeat (4) tick();
    check("ld4_done", {29'd0, busy, done, error}, 32'b010);

    // Length exactly 0x8000 is legal.
    pulse_start();
    send_byte(8'h80, 0); send_byte(8'h00, 0);
    check("ld5_max_len_ok", {29'd0, busy, done, error}, 32'b100);
    check("ld5_in_ready", {31'd0, in_ready}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_a");
    tick(); reset = 1'b0;

    // Reset after three bytes of a load, checked before any clock edge.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
    #2 reset = 1'b1;
    #1 check_reset_vals("rst_b");
    tick(); reset = 1'b0;
    tick();
    check("rst_b_idle", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(15'd0, 16'hBEEF, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
`else
    tick();
`endif
    check("ld6_done", {29'd0, busy, done, error}, 32'b010);

`ifdef LOADER_CHECKSUM_EN
    // Sum of 0001 + FFFF wraps to 0000.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(15'd0, 16'h0001, 0); send_word(15'd1, 16'hFFFF, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("chk_ok_done", {29'd0, busy, done, error}, 32'b010);
    check("chk_ok_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(15'd0, 16'h0001, 0); send_word(15'd1, 16'hFFFF, 0);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    check("chk_bad_err", {29'd0, busy, done, error}, 32'b001);
    check("chk_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`endif

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
